demux_conductual: RTL and testbench



---
 rtl/demux_pkg.sv | 13 +
 rtl/demux_conductual.sv | 82 ++++++++
 tb/tb_demux_conductual.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the interleaving mux/demux pair.
// Both stages import WIDTH_DEF so they agree on word width.
package demux_pkg;

   localparam int WIDTH_DEF = 4;
   localparam int CNT_W_DEF = 8;

   typedef enum logic {
      EXPECT_L1 = 1'b0,
      EXPECT_L0 = 1'b1
   } phase_t;

endpackage

// File: rtl/demux_conductual.sv
// 1-to-2 demultiplexer: splits an interleaved word stream back into two lanes.
// The first word of each pair is lane 1 and the second is lane 0.
//
// state     | meaning
// ----------+---------------------------------------------------------
// EXPECT_L1 | waiting for the first word of a pair (the lane-1 word)
// EXPECT_L0 | lane-1 word is held; the next valid word completes the pair
module demux_conductual
   import demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
   output logic [WIDTH-1:0] data_out_0,
   output logic [WIDTH-1:0] data_out_1,
   output logic             valid_out,
   output logic [CNT_W-1:0] pair_count
);

   phase_t             r_state;
   phase_t             w_state_nxt;
   logic               w_capture;
   logic               w_pair_done;
   logic [WIDTH-1:0]   r_hold;
   logic [WIDTH-1:0]   r_data_out_0;
   logic [WIDTH-1:0]   r_data_out_1;
   logic               r_valid_out;
   logic [CNT_W-1:0]   r_pair_count;

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_pair_done = 1'b0;
      if (valid_in) begin
         case (r_state)
            EXPECT_L1: begin
               w_capture   = 1'b1;
               w_state_nxt = EXPECT_L0;
            end
            EXPECT_L0: begin
               w_pair_done = 1'b1;
               w_state_nxt = EXPECT_L1;
            end
            default: w_state_nxt = EXPECT_L1;
         endcase
      end
   end

   // A stall (valid_in=0) leaves everything but the strobe untouched,
   // so a gap of any length may sit between the two words of a pair.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state      <= EXPECT_L1;
         r_hold       <= '0;
         r_data_out_0 <= '0;
         r_data_out_1 <= '0;
         r_valid_out  <= 1'b0;
         r_pair_count <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_valid_out <= w_pair_done;
         if (w_capture) begin
            r_hold <= data_in;
         end
         if (w_pair_done) begin
            r_data_out_1 <= r_hold;
            r_data_out_0 <= data_in;
            r_pair_count <= r_pair_count + 1'b1;
         end
      end
   end

   assign data_out_0 = r_data_out_0;
   assign data_out_1 = r_data_out_1;
   assign valid_out  = r_valid_out;
   assign pair_count = r_pair_count;

endmodule

// File: tb/tb_demux_conductual.sv
// Directed bench for demux_conductual: reset, pairing, gaps, mid-pair reset, counter wrap.
module tb_demux_conductual;

   logic       clk;
   logic       reset_L;
   logic [3:0] data_in;
   logic       valid_in;
   logic [3:0] data_out_0;
   logic [3:0] data_out_1;
   logic       valid_out;
   logic [7:0] pair_count;

   int errors = 0;
   int checks = 0;

   demux_conductual #(.WIDTH(4), .CNT_W(8)) dut (
      .clk        (clk),
      .reset_L    (reset_L),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .data_out_0 (data_out_0),
      .data_out_1 (data_out_1),
      .valid_out  (valid_out),
      .pair_count (pair_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change 1 time unit after a rising edge; outputs sampled at the same point
   task automatic step(input logic v, input logic [3:0] d);
      valid_in = v;
      data_in  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 4'h0;
      @(posedge clk);
      #1;
      reset_L = 1'b1;
   endtask

   task automatic test_reset();
      reset_L  = 1'b0;
      valid_in = 1'b1;
      data_in  = 4'hF;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({data_out_1, data_out_0, valid_out, pair_count} !== 17'h0) begin
            errors++;
            $display("FAIL reset_hold cycle %0d: got d1=%h d0=%h v=%b cnt=%0d, want all 0",
                     i, data_out_1, data_out_0, valid_out, pair_count);
         end
      end
      valid_in = 1'b0;
      data_in  = 4'h0;
      reset_L  = 1'b1;
   endtask

   task automatic test_basic();
      do_reset();
      step(1'b1, 4'hA);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL basic_first_word: got valid_out=%b, want 0", valid_out);
      end
      step(1'b1, 4'h5);
      checks++;
      if (data_out_1 !== 4'hA || data_out_0 !== 4'h5 || valid_out !== 1'b1 || pair_count !== 8'd1) begin
         errors++;
         $display("FAIL basic_pair: got d1=%h d0=%h v=%b cnt=%0d, want d1=a d0=5 v=1 cnt=1",
                  data_out_1, data_out_0, valid_out, pair_count);
      end
      step(1'b0, 4'h0);
      checks++;
      if (valid_out !== 1'b0 || data_out_1 !== 4'hA || data_out_0 !== 4'h5) begin
         errors++;
         $display("FAIL basic_strobe_len: got d1=%h d0=%h v=%b, want d1=a d0=5 v=0",
                  data_out_1, data_out_0, valid_out);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_d1 [3] = '{4'h1, 4'h3, 4'h5};
      logic [3:0] exp_d0 [3] = '{4'h2, 4'h4, 4'h6};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 4'(i + 1));
         checks++;
         if (valid_out !== ((i % 2) == 1)) begin
            errors++;
            $display("FAIL stream_valid word %0d: got %b, want %b", i + 1, valid_out, (i % 2) == 1);
         end
         if ((i % 2) == 1) begin
            checks++;
            if (data_out_1 !== exp_d1[i/2] || data_out_0 !== exp_d0[i/2] || pair_count !== 8'(i/2 + 1)) begin
               errors++;
               $display("FAIL stream_pair %0d: got d1=%h d0=%h cnt=%0d, want d1=%h d0=%h cnt=%0d",
                        i/2, data_out_1, data_out_0, pair_count, exp_d1[i/2], exp_d0[i/2], i/2 + 1);
            end
         end
      end
      step(1'b0, 4'h0);
      checks++;
      if (pair_count !== 8'd3 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL stream_end: got cnt=%0d v=%b, want cnt=3 v=0", pair_count, valid_out);
      end
   endtask

   task automatic test_gap();
      do_reset();
      step(1'b1, 4'h7);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 4'hE);
         checks++;
         if (valid_out !== 1'b0 || data_out_1 !== 4'h0 || data_out_0 !== 4'h0 || pair_count !== 8'd0) begin
            errors++;
            $display("FAIL gap_hold cycle %0d: got d1=%h d0=%h v=%b cnt=%0d, want all 0",
                     i, data_out_1, data_out_0, valid_out, pair_count);
         end
      end
      step(1'b1, 4'h9);
      checks++;
      if (data_out_1 !== 4'h7 || data_out_0 !== 4'h9 || valid_out !== 1'b1 || pair_count !== 8'd1) begin
         errors++;
         $display("FAIL gap_pair: got d1=%h d0=%h v=%b cnt=%0d, want d1=7 d0=9 v=1 cnt=1",
                  data_out_1, data_out_0, valid_out, pair_count);
      end
   endtask

   task automatic test_reset_mid_pair();
      do_reset();
      step(1'b1, 4'hC);
      valid_in = 1'b0;
      #1 reset_L = 1'b0;
      #1;
      checks++;
      if ({data_out_1, data_out_0, valid_out, pair_count} !== 17'h0) begin
         errors++;
         $display("FAIL async_reset: got d1=%h d0=%h v=%b cnt=%0d, want all 0",
                  data_out_1, data_out_0, valid_out, pair_count);
      end
      #1 reset_L = 1'b1;
      step(1'b1, 4'h3);
      checks++;
      if (valid_out !== 1'b0) begin
         errors++;
         $display("FAIL midreset_no_strobe: got valid_out=%b, want 0", valid_out);
      end
      step(1'b1, 4'h4);
      checks++;
      if (data_out_1 !== 4'h3 || data_out_0 !== 4'h4 || valid_out !== 1'b1 || pair_count !== 8'd1) begin
         errors++;
         $display("FAIL midreset_pair: got d1=%h d0=%h v=%b cnt=%0d, want d1=3 d0=4 v=1 cnt=1",
                  data_out_1, data_out_0, valid_out, pair_count);
      end
   endtask

   task automatic test_wrap();
      logic [3:0] w1;
      do_reset();
      for (int p = 1; p <= 256; p++) begin
         w1 = 4'(p);
         step(1'b1, w1);
         step(1'b1, ~w1);
         if (p == 255) begin
            checks++;
            if (pair_count !== 8'd255 || valid_out !== 1'b1) begin
               errors++;
               $display("FAIL wrap_255: got cnt=%0d v=%b, want cnt=255 v=1", pair_count, valid_out);
            end
         end
         if (p == 256) begin
            checks++;
            if (pair_count !== 8'd0 || valid_out !== 1'b1 || data_out_1 !== 4'h0 || data_out_0 !== 4'hF) begin
               errors++;
               $display("FAIL wrap_256: got cnt=%0d v=%b d1=%h d0=%h, want cnt=0 v=1 d1=0 d0=f",
                        pair_count, valid_out, data_out_1, data_out_0);
            end
         end
      end
   endtask

   initial begin
      reset_L  = 1'b0;
      valid_in = 1'b0;
      data_in  = 4'h0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_gap();
      test_reset_mid_pair();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
